// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM loader: command bytes, FSM states, RAM geometry.
// The STATUS state exists only when SPI_RAM_LOADER_STATUS_EN is defined.
package spi_ram_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;
    localparam int RAM_DATA_W = 8;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WRITE,
        ST_READ,
`ifdef SPI_RAM_LOADER_STATUS_EN
        ST_STATUS,
`endif
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_loader_if.sv
// RAM-side bus of the loader: write port and registered read port of SPI_RAM.
interface spi_ram_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        o_w_Data;
    logic              o_w_Enable;
    logic [ADDR_W-1:0] o_w_Address;
    logic [ADDR_W-1:0] o_r_Address;
    logic [7:0]        i_r_Data;

    modport master (
        output o_w_Data, o_w_Enable, o_w_Address, o_r_Address,
        input  i_r_Data
    );

    modport slave (
        input  o_w_Data, o_w_Enable, o_w_Address, o_r_Address,
        output i_r_Data
    );
endinterface

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave pin layer: input synchronisers, SCK/CS edge detection,
// RX byte assembly with a byte_valid pulse and a loadable TX shifter for MISO.
module spi_slave_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       selected,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    input  logic       tx_en
);

    logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
    logic       sck_s, mosi_s, cs_s;
    logic       sck_d, cs_d, armed;
    logic       sck_rise, sck_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;

    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    // A CS fall only opens a transaction once CS has been seen high since reset.
    assign cs_fall  = armed & cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign selected = armed & ~cs_s;
    assign spi_miso = tx_shift[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q      <= '0;
            mosi_q     <= '0;
            cs_q       <= '0;
            sck_d      <= 1'b0;
            cs_d       <= 1'b0;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            tx_shift   <= '0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], spi_clk};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            cs_q       <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_d      <= sck_s;
            cs_d       <= cs_s;
            byte_valid <= 1'b0;
            if (cs_s) begin
                armed <= 1'b1;
            end

            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {rx_shift, mosi_s};
                end
            end

            // The fall after the 8th rise keeps bit7 of the freshly loaded byte.
            if (!tx_en) begin
                tx_shift <= '0;
            end else if (tx_load) begin
                tx_shift <= tx_data;
            end else if (sck_fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_ram_loader.sv
// SPI command front-end owning both ports of the dual-port byte RAM.
// Optional SPI_RAM_LOADER_STATUS_EN adds command 0x05 returning the write-byte count.
module spi_ram_loader
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_SPI_Clk,
    input  logic i_SPI_MOSI,
    input  logic i_SPI_CS_n,
    output logic o_SPI_MISO,
    output logic o_Busy,
    spi_ram_loader_if.master ram
);

    state_t                state;
    logic                  write_mode;
    logic [ADDR_W-1:0]     addr;
    logic                  rd_p1, rd_p2;
    logic [RAM_DATA_W-1:0] w_data;
    logic                  w_en;
    logic [ADDR_W-1:0]     w_addr, r_addr;
    logic                  cs_fall, cs_rise, selected, byte_valid;
    logic [7:0]            rx_byte;
    logic                  tx_load, tx_en;
    logic [7:0]            tx_data;

`ifdef SPI_RAM_LOADER_STATUS_EN
    logic [7:0] wr_count;
    logic       st_load;
    assign tx_en   = (state == ST_READ) || (state == ST_STATUS);
    assign tx_load = rd_p2 | st_load;
    assign tx_data = rd_p2 ? ram.i_r_Data : wr_count;
`else
    assign tx_en   = (state == ST_READ);
    assign tx_load = rd_p2;
    assign tx_data = ram.i_r_Data;
`endif

    assign ram.o_w_Data    = w_data;
    assign ram.o_w_Enable  = w_en;
    assign ram.o_w_Address = w_addr;
    assign ram.o_r_Address = r_addr;

    spi_slave_phy #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_phy (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .spi_clk   (i_SPI_Clk),
        .spi_mosi  (i_SPI_MOSI),
        .spi_cs_n  (i_SPI_CS_n),
        .spi_miso  (o_SPI_MISO),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .selected  (selected),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .tx_en     (tx_en)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= ST_IDLE;
            write_mode <= 1'b0;
            addr       <= '0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            w_data     <= '0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            r_addr     <= '0;
            o_Busy     <= 1'b0;
`ifdef SPI_RAM_LOADER_STATUS_EN
            wr_count   <= '0;
            st_load    <= 1'b0;
`endif
        end else begin
            o_Busy <= selected;
            w_en   <= 1'b0;
            rd_p1  <= 1'b0;
            rd_p2  <= rd_p1;
`ifdef SPI_RAM_LOADER_STATUS_EN
            st_load <= 1'b0;
`endif
            // Read data is captured into TX this cycle; prefetch the next byte.
            if (rd_p2) begin
                addr   <= addr + 1'b1;
                r_addr <= addr + 1'b1;
            end

            if (cs_rise) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (byte_valid) begin
                            case (rx_byte)
                                CMD_WRITE: begin
                                    write_mode <= 1'b1;
                                    state      <= ST_ADDR_HI;
                                end
                                CMD_READ: begin
                                    write_mode <= 1'b0;
                                    state      <= ST_ADDR_HI;
                                end
`ifdef SPI_RAM_LOADER_STATUS_EN
                                CMD_STATUS: begin
                                    state   <= ST_STATUS;
                                    st_load <= 1'b1;
                                end
`endif
                                default: state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR_HI: begin
                        if (byte_valid) begin
                            addr[ADDR_W-1:8] <= rx_byte[ADDR_W-9:0];
                            state            <= ST_ADDR_LO;
                        end
                    end
                    ST_ADDR_LO: begin
                        if (byte_valid) begin
                            addr[7:0] <= rx_byte;
                            if (write_mode) begin
                                state <= ST_WRITE;
                            end else begin
                                state  <= ST_READ;
                                r_addr <= {addr[ADDR_W-1:8], rx_byte};
                                rd_p1  <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (byte_valid) begin
                            w_en   <= 1'b1;
                            w_addr <= addr;
                            w_data <= rx_byte;
                            addr   <= addr + 1'b1;
`ifdef SPI_RAM_LOADER_STATUS_EN
                            wr_count <= wr_count + 8'd1;
`endif
                        end
                    end
                    ST_READ: begin
                        if (byte_valid) begin
                            r_addr <= addr;
                            rd_p1  <= 1'b1;
                        end
                    end
`ifdef SPI_RAM_LOADER_STATUS_EN
                    ST_STATUS: begin
                        if (byte_valid) st_load <= 1'b1;
                    end
`endif
                    ST_IGNORE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_loader.sv
// Self-checking bench for spi_ram_loader: SPI master BFM, RAM behavioural model,
// write scoreboard queue and read-back expectations kept in a bench-side memory image.
module tb_spi_ram_loader;
    import spi_ram_pkg::*;

    localparam int ADDR_W = 10;
    localparam int HALF   = 8;

    logic clk = 1'b0;
    logic rst, sck, mosi, cs_n, miso, busy, mem_init;
    logic [7:0] mem     [RAM_DEPTH];
    logic [7:0] exp_mem [RAM_DEPTH];
    logic [17:0] wq[$];
    logic [7:0]  rq[$];
    int checks = 0, errors = 0, strobes = 0, wr_total = 0;

    typedef struct {
        logic [7:0] hi, lo;
        logic [9:0] base;
        logic [7:0] d0, d1, d2;
    } vec_t;
    vec_t tbl [4];

    spi_ram_loader_if #(.ADDR_W(ADDR_W)) ram_if ();

    spi_ram_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_SPI_Clk (sck),
        .i_SPI_MOSI(mosi),
        .i_SPI_CS_n(cs_n),
        .o_SPI_MISO(miso),
        .o_Busy    (busy),
        .ram       (ram_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (ram_if.o_w_Enable) begin
            mem[ram_if.o_w_Address] <= ram_if.o_w_Data;
        end
        ram_if.i_r_Data <= mem[ram_if.o_r_Address];
    end

    always @(negedge clk) begin
        if (ram_if.o_w_Enable === 1'b1) begin
            logic [17:0] e;
            strobes++;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got addr=%h data=%h, expected no write",
                         ram_if.o_w_Address, ram_if.o_w_Data);
            end else begin
                e = wq.pop_front();
                if ({ram_if.o_w_Address, ram_if.o_w_Data} !== e) begin
                    errors++;
                    $display("FAIL write_strobe: got addr=%h data=%h, expected addr=%h data=%h",
                             ram_if.o_w_Address, ram_if.o_w_Data, e[17:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx;
        spi_xfer(tx, 8, rx);
    endtask

    task automatic cs_open();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_close();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [7:0] d);
        wq.push_back({a, d});
        exp_mem[a] = d;
        wr_total++;
    endtask

    task automatic write_bytes(input logic [7:0] hi, input logic [7:0] lo, input logic [9:0] base,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        cs_open();
        send(CMD_WRITE); send(hi); send(lo);
        push_wr(base, d0);        send(d0);
        push_wr(base + 10'd1, d1); send(d1);
        push_wr(base + 10'd2, d2); send(d2);
        cs_close();
    endtask

    task automatic read_check(input logic [9:0] a, input int n, input string name);
        logic [7:0] rx;
        logic [9:0] p;
        p = a;
        cs_open();
        send(CMD_READ); send({6'b0, a[9:8]}); send(a[7:0]);
        for (int i = 0; i < n; i++) begin
            rq.push_back(exp_mem[p]);
            p = p + 10'd1;
            spi_xfer(8'h00, 8, rx);
            chk(name, {24'b0, rx}, {24'b0, rq.pop_front()});
        end
        cs_close();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_w_en"},   {31'b0, ram_if.o_w_Enable}, 32'd0);
        chk({tag, "_w_addr"}, {22'b0, ram_if.o_w_Address}, 32'd0);
        chk({tag, "_w_data"}, {24'b0, ram_if.o_w_Data}, 32'd0);
        chk({tag, "_r_addr"}, {22'b0, ram_if.o_r_Address}, 32'd0);
        chk({tag, "_miso"},   {31'b0, miso}, 32'd0);
        chk({tag, "_busy"},   {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [7:0] rx, acc;

        tbl[0] = '{hi: 8'h00, lo: 8'h80, base: 10'h080, d0: 8'h11, d1: 8'h22, d2: 8'h33};
        tbl[1] = '{hi: 8'h00, lo: 8'hFF, base: 10'h0FF, d0: 8'h44, d1: 8'h55, d2: 8'h66};
        tbl[2] = '{hi: 8'hFD, lo: 8'h80, base: 10'h180, d0: 8'h77, d1: 8'h88, d2: 8'h99};
        tbl[3] = '{hi: 8'h02, lo: 8'h00, base: 10'h200, d0: 8'h12, d1: 8'h34, d2: 8'h56};
        for (int i = 0; i < RAM_DEPTH; i++) exp_mem[i] = 8'(i * 7 + 3);

        rst = 1'b1; mem_init = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0; mem_init = 1'b0;
        repeat (8) @(negedge clk);

        // Write with address wrap at the top of the RAM.
        s0 = strobes;
        cs_open();
        send(8'h02); send(8'h03); send(8'hFE);
        push_wr(10'h3FE, 8'hAA); send(8'hAA);
        push_wr(10'h3FF, 8'hBB); send(8'hBB);
        push_wr(10'h000, 8'hCC); send(8'hCC);
        cs_close();
        chk("wrap_strobes", strobes - s0, 3);
        chk("wrap_queue_empty", wq.size(), 0);

        cs_open();
        chk("busy_when_selected", {31'b0, busy}, 32'd1);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("busy_after_deselect", {31'b0, busy}, 32'd0);

        read_check(10'h3FE, 3, "wrap_readback");

        // Table of write/read-back vectors, including the upper address bits being ignored.
        for (int i = 0; i < 4; i++) begin
            s0 = strobes;
            write_bytes(tbl[i].hi, tbl[i].lo, tbl[i].base, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            chk("table_strobes", strobes - s0, 3);
            read_check(tbl[i].base, 3, "table_readback");
        end

        // Abort with a partial data byte.
        s0 = strobes;
        cs_open();
        send(8'h02); send(8'h00); send(8'h10);
        spi_xfer(8'hE7, 5, rx);
        cs_close();
        chk("abort_strobes", strobes - s0, 0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_miso", {31'b0, miso}, 32'd0);
        read_check(10'h010, 1, "abort_readback");

        // Unknown command: no writes, MISO quiet.
        s0 = strobes;
        acc = '0;
        cs_open();
        spi_xfer(8'h7E, 8, rx); acc = acc | rx;
        spi_xfer(8'h00, 8, rx); acc = acc | rx;
        spi_xfer(8'h00, 8, rx); acc = acc | rx;
        spi_xfer(8'h11, 8, rx); acc = acc | rx;
        spi_xfer(8'h22, 8, rx); acc = acc | rx;
        cs_close();
        chk("unknown_miso", {24'b0, acc}, 32'd0);
        chk("unknown_strobes", strobes - s0, 0);
        read_check(10'h000, 2, "unknown_ram_intact");

        // Reset in the middle of a write burst with CS still low.
        s0 = strobes;
        cs_open();
        send(8'h02); send(8'h00); send(8'h20);
        push_wr(10'h020, 8'h11); send(8'h11);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        wr_total = 0;
        send(8'h22);
        cs_close();
        chk("midreset_strobes", strobes - s0, 1);
        chk("midreset_queue_empty", wq.size(), 0);
        read_check(10'h020, 2, "midreset_readback");

        // Status command after four written bytes.
        s0 = strobes;
        cs_open();
        send(8'h02); send(8'h00); send(8'h40);
        for (int i = 0; i < 4; i++) begin
            push_wr(10'h040 + 10'(i), 8'(8'hD0 + i));
            send(8'(8'hD0 + i));
        end
        cs_close();
        chk("status_pre_strobes", strobes - s0, 4);
        s0 = strobes;
        cs_open();
        send(8'h05);
        spi_xfer(8'h00, 8, rx);
`ifdef SPI_RAM_LOADER_STATUS_EN
        chk("status_count", {24'b0, rx}, 32'(wr_total % 256));
        spi_xfer(8'h00, 8, rx);
        chk("status_repeat", {24'b0, rx}, 32'(wr_total % 256));
`else
        chk("status_disabled", {24'b0, rx}, 32'd0);
`endif
        cs_close();
        chk("status_strobes", strobes - s0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
